// File: rtl/tx_mod_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : tx_mod_pkg
//  Description : Shared types and constants for the QAM symbol mapper:
//                FSM state encoding, legal modulation orders, Gray-coded
//                PAM level tables and the per-order amplitude step tables.
//  Revision    : 1.0  initial release
// ============================================================================
package tx_mod_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] C_ORDER_1 = 3'd1;
  localparam logic [2:0] C_ORDER_2 = 3'd2;
  localparam logic [2:0] C_ORDER_4 = 3'd4;
  localparam logic [2:0] C_ORDER_6 = 3'd6;

  // Gray-coded PAM levels indexed by the raw per-axis bit field.
  localparam int C_GRAY_K1 [2] = '{-1, 1};
  localparam int C_GRAY_K2 [4] = '{-3, -1, 3, 1};
  localparam int C_GRAY_K3 [8] = '{-7, -5, -1, -3, 7, 5, 1, 3};

  // Step tables indexed by order slot (orders 1, 2, 4, 6 -> slots 0..3).
  // Normalised steps give unit average power; the plain table holds the
  // shift below the amplitude width, i.e. step = 2^(AMP_W - shift).
  localparam int C_STEP_NORM      [4] = '{1448, 1024, 458, 223};
  localparam int C_STEP_PLAIN_SHR [4] = '{4, 4, 4, 4};

  function automatic logic is_legal(input logic [2:0] order);
    return (order == C_ORDER_1) || (order == C_ORDER_2) ||
           (order == C_ORDER_4) || (order == C_ORDER_6);
  endfunction

  function automatic int order_slot(input logic [2:0] order);
    case (order)
      C_ORDER_2: return 1;
      C_ORDER_4: return 2;
      C_ORDER_6: return 3;
      default:   return 0;
    endcase
  endfunction

  function automatic int gray_level(input logic [2:0] bits, input int k);
    case (k)
      1:       return C_GRAY_K1[bits[0]];
      2:       return C_GRAY_K2[bits[1:0]];
      3:       return C_GRAY_K3[bits];
      default: return 0;
    endcase
  endfunction

  function automatic int step_norm(input logic [2:0] order);
    return C_STEP_NORM[order_slot(order)];
  endfunction

  function automatic int step_plain(input logic [2:0] order, input int amp_w);
    return 1 << (amp_w - C_STEP_PLAIN_SHR[order_slot(order)]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sym_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sym_fifo
//  Description : Synchronous FIFO with combinational read data (head entry
//                always visible on rdata). A push while full is dropped unless
//                a pop happens on the same edge, in which case both occur.
//  Ports       : clk, rst (async, active-high), push, pop, wdata,
//                rdata, full, empty, count
//  Revision    : 1.0  initial release
// ============================================================================
module sym_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int C_PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_PTR_W:0]   r_count;
  logic               w_wr_en;
  logic               w_rd_en;

  assign w_rd_en = pop && !empty;
  assign w_wr_en = push && (!full || w_rd_en);

  // Storage needs no reset: entries are only observable once written.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= wdata;
  end

  // Power-of-two depth: pointers wrap naturally by overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign full  = (r_count == (C_PTR_W+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/qam_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : qam_mapper
//  Description : Maps upstream words to Gray-coded I/Q amplitudes for
//                BPSK/QPSK/16-QAM/64-QAM and buffers them in a symbol FIFO
//                for the downstream shaping filter. An order change drains
//                the buffer before the new order takes effect.
//  Ports       : clk, rst (async, active-high), modOrder, oreq, ival, ibit,
//                ireq, oval, oI, oQ, ounderflow
//  Options     : QAM_MAPPER_NORM_EN - unit-average-power step table instead
//                of the fixed 2^(AMP_W-4) step.
//  Revision    : 1.0  initial release
// ============================================================================
module qam_mapper
  import tx_mod_pkg::*;
#(
  parameter int maxWordOut = 6,
  parameter int AMP_W      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              modOrder,
  output logic                    oreq,
  input  logic                    ival,
  input  logic [maxWordOut-1:0]   ibit,
  input  logic                    ireq,
  output logic                    oval,
  output logic signed [AMP_W-1:0] oI,
  output logic signed [AMP_W-1:0] oQ,
  output logic                    ounderflow
);

  localparam int C_CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int C_AMP_MAX = (1 << (AMP_W-1)) - 1;
  localparam int C_AMP_MIN = -(1 << (AMP_W-1));
  // Keep one slot free for a word that may already be on its way.
  localparam logic [C_CNT_W-1:0] C_OREQ_MAX = C_CNT_W'(FIFO_DEPTH - 2);

  state_t                 r_state, w_state_nxt;
  logic [2:0]             r_order, w_order_nxt;
  logic [5:0]             w_bits;
  int                     w_lvl_i, w_lvl_q, w_step;
  logic [2*AMP_W-1:0]     w_wdata, w_rdata;
  logic                   w_full, w_empty, w_pop;
  logic [C_CNT_W-1:0]     w_count;
  logic                   r_oval, r_uflow;
  logic signed [AMP_W-1:0] r_oi, r_oq;

  function automatic logic [AMP_W-1:0] sat_amp(input int v);
    if (v > C_AMP_MAX)      return C_AMP_MAX[AMP_W-1:0];
    else if (v < C_AMP_MIN) return C_AMP_MIN[AMP_W-1:0];
    else                    return v[AMP_W-1:0];
  endfunction

  // ---------------------------------------------------------------- FSM ---
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_order <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_order <= w_order_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_order_nxt = r_order;
    oreq        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (is_legal(modOrder)) begin
          w_state_nxt = ST_RUN;
          w_order_nxt = modOrder;
        end
      end
      ST_RUN: begin
        oreq = (w_count <= C_OREQ_MAX);
        if (is_legal(modOrder) && (modOrder != r_order)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Switch only once nothing mapped with the old order is left.
        if (w_empty && !ival) begin
          w_state_nxt = ST_RUN;
          if (is_legal(modOrder)) w_order_nxt = modOrder;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------ mapping ---
  assign w_bits = 6'(ibit);

  always_comb begin
    w_lvl_i = 0;
    w_lvl_q = 0;
    case (r_order)
      C_ORDER_1: w_lvl_i = gray_level({2'b00, w_bits[0]}, 1);
      C_ORDER_2: begin
        w_lvl_i = gray_level({2'b00, w_bits[1]}, 1);
        w_lvl_q = gray_level({2'b00, w_bits[0]}, 1);
      end
      C_ORDER_4: begin
        w_lvl_i = gray_level({1'b0, w_bits[3:2]}, 2);
        w_lvl_q = gray_level({1'b0, w_bits[1:0]}, 2);
      end
      C_ORDER_6: begin
        w_lvl_i = gray_level(w_bits[5:3], 3);
        w_lvl_q = gray_level(w_bits[2:0], 3);
      end
      default: ;
    endcase
  end

`ifdef QAM_MAPPER_NORM_EN
  assign w_step = step_norm(r_order);
`else
  assign w_step = step_plain(r_order, AMP_W);
`endif

  assign w_wdata = {sat_amp(w_lvl_i * w_step), sat_amp(w_lvl_q * w_step)};

  // --------------------------------------------------------------- FIFO ---
  // The FIFO entry itself is the register that captures the mapped symbol
  // on the edge after acceptance.
  sym_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*AMP_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ival),
    .pop   (ireq),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_pop = ireq && !w_empty;

  // ------------------------------------------------------------ outputs ---
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_oval  <= 1'b0;
      r_oi    <= '0;
      r_oq    <= '0;
      r_uflow <= 1'b0;
    end else begin
      r_oval <= w_pop;
      if (w_pop) begin
        r_oi <= w_rdata[2*AMP_W-1:AMP_W];
        r_oq <= w_rdata[AMP_W-1:0];
      end else begin
        r_oi <= '0;
        r_oq <= '0;
      end
      if ((r_state == ST_RUN) && ireq && w_empty) r_uflow <= 1'b1;
    end
  end

  assign oval       = r_oval;
  assign oI         = r_oi;
  assign oQ         = r_oq;
  assign ounderflow = r_uflow;

  // Full is implied by count; kept on the FIFO interface for other users.
  logic w_unused;
  assign w_unused = w_full;

endmodule
`default_nettype wire

// File: tb/tb_qam_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qam_mapper
//  Description : Self-checking bench for qam_mapper. A queue-based reference
//                model derives Gray levels arithmetically; a monitor compares
//                every presented symbol against the expected-symbol queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_qam_mapper;

  localparam int W  = 6;
  localparam int AW = 12;
  localparam int D  = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [2:0]           modOrder = 3'd0;
  logic                 oreq;
  logic                 ival = 1'b0;
  logic [W-1:0]         ibit = '0;
  logic                 ireq = 1'b0;
  logic                 oval;
  logic signed [AW-1:0] oI, oQ;
  logic                 ounderflow;

  qam_mapper #(.maxWordOut(W), .AMP_W(AW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .modOrder(modOrder), .oreq(oreq), .ival(ival),
    .ibit(ibit), .ireq(ireq), .oval(oval), .oI(oI), .oQ(oQ),
    .ounderflow(ounderflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------ reference model
  typedef struct { int i; int q; } sym_t;

  sym_t mfifo[$];
  sym_t expq[$];
  int   m_state = 0;  // 0 idle, 1 run, 2 drain
  int   m_order = 0;
  bit   m_uf    = 1'b0;

  function automatic bit legal(int o);
    return (o == 1) || (o == 2) || (o == 4) || (o == 6);
  endfunction

  function automatic int step_of(int o);
`ifdef QAM_MAPPER_NORM_EN
    case (o)
      1: return 1448;
      2: return 1024;
      4: return 458;
      default: return 223;
    endcase
`else
    return 1 << (AW - 4);
`endif
  endfunction

  // Gray -> binary, then binary index -> odd PAM level.
  function automatic int level(int g, int k);
    int b = 0;
    for (int s = 0; s < k; s++) b = b ^ (g >> s);
    return 2 * b - ((1 << k) - 1);
  endfunction

  function automatic int sat(int v);
    int hi = (1 << (AW - 1)) - 1;
    int lo = -(1 << (AW - 1));
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  function automatic sym_t map_word(int o, int word);
    sym_t r;
    int k;
    r.i = 0;
    r.q = 0;
    if (o == 1) begin
      r.i = sat(level(word & 1, 1) * step_of(o));
    end else if (legal(o)) begin
      k = o / 2;
      r.i = sat(level((word >> k) & ((1 << k) - 1), k) * step_of(o));
      r.q = sat(level(word & ((1 << k) - 1), k) * step_of(o));
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    int   occ;
    bit   pop;
    sym_t s;
    int   ns, no;
    if (rst) begin
      mfifo.delete();
      expq.delete();
      m_state = 0;
      m_order = 0;
      m_uf    = 1'b0;
    end else begin
      occ = mfifo.size();
      pop = ireq && (occ > 0);
      s   = map_word(m_order, int'(ibit));
      ns  = m_state;
      no  = m_order;
      if (m_state == 1 && ireq && occ == 0) m_uf = 1'b1;
      case (m_state)
        0: if (legal(int'(modOrder))) begin ns = 1; no = int'(modOrder); end
        1: if (legal(int'(modOrder)) && int'(modOrder) != m_order) ns = 2;
        default: if (occ == 0 && !ival) begin
          ns = 1;
          if (legal(int'(modOrder))) no = int'(modOrder);
        end
      endcase
      if (pop) expq.push_back(mfifo.pop_front());
      if (ival && (occ < D || pop)) mfifo.push_back(s);
      m_state = ns;
      m_order = no;
    end
  end

  // -------------------------------------------------------------- monitor
  always @(negedge clk) begin
    sym_t e;
    if (!rst) begin
      if (oval) begin
        if (expq.size() == 0) begin
          chk("unexpected_oval", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("sym_I", int'(oI), e.i);
          chk("sym_Q", int'(oQ), e.q);
        end
      end else begin
        chk("missing_oval", expq.size(), 0);
        if (expq.size() != 0) void'(expq.pop_front());
        chk("idle_IQ_zero", int'(oI) | int'(oQ), 0);
      end
      chk("oreq", int'(oreq), int'(m_state == 1 && mfifo.size() <= D - 2));
      chk("ounderflow", int'(ounderflow), int'(m_uf));
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input int w);
    ival = 1'b1;
    ibit = W'(w);
    cyc(1);
    ival = 1'b0;
  endtask

  initial begin
    int n;
    int pv[4] = '{50, 85, 15, 60};
    int pr[4] = '{50, 15, 85, 60};

    cyc(3);
    chk("rst_oreq", int'(oreq), 0);
    chk("rst_oval", int'(oval), 0);
    chk("rst_oI", int'(oI), 0);
    chk("rst_oQ", int'(oQ), 0);
    chk("rst_uflow", int'(ounderflow), 0);
    rst = 1'b0;

    // QPSK point: I from bit1, Q from bit0.
    modOrder = 3'd2;
    cyc(1);
    chk("oreq_after_start", int'(oreq), 1);
    push_word(6'b000010);
    ireq = 1'b1;
    cyc(1);
    ireq = 1'b0;
`ifdef QAM_MAPPER_NORM_EN
    chk("qpsk_I", int'(oI), 1024);
    chk("qpsk_Q", int'(oQ), -1024);
`else
    chk("qpsk_I", int'(oI), 256);
    chk("qpsk_Q", int'(oQ), -256);
`endif

    // 64-QAM corner point, reached through a drain with an empty FIFO.
    modOrder = 3'd6;
    cyc(2);
    push_word(6'b100000);
    ireq = 1'b1;
    cyc(1);
    ireq = 1'b0;
`ifdef QAM_MAPPER_NORM_EN
    chk("qam64_I", int'(oI), 1561);
    chk("qam64_Q", int'(oQ), -1561);
`else
    chk("qam64_I", int'(oI), 1792);
    chk("qam64_Q", int'(oQ), -1792);
`endif

    // 16-QAM: fill to three (request drops), force two more (one dropped).
    modOrder = 3'd4;
    cyc(2);
    for (int i = 0; i < 3; i++) push_word($urandom);
    chk("oreq_three_entries", int'(oreq), 0);
    for (int i = 0; i < 2; i++) push_word($urandom);
    n = 0;
    ireq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      n += int'(oval);
    end
    ireq = 1'b0;
    chk("full_kept_four", n, 4);

    // Order change with two words buffered: drain at old order.
    push_word(6'b001101);
    push_word(6'b110010);
    modOrder = 3'd2;
    cyc(1);
    chk("drain_oreq", int'(oreq), 0);
    ireq = 1'b1;
    cyc(3);
    ireq = 1'b0;
    chk("drain_no_uflow", int'(ounderflow), 0);
    cyc(1);
    chk("back_to_run", int'(oreq), 1);

    // Underflow in RUN, sticky.
    ireq = 1'b1;
    cyc(1);
    ireq = 1'b0;
    chk("uflow_set", int'(ounderflow), 1);
    chk("uflow_oval", int'(oval), 0);
    cyc(3);
    chk("uflow_sticky", int'(ounderflow), 1);

    // Randomised traffic, with an asynchronous reset mid-burst.
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 300; c++) begin
        ival = ($urandom_range(99) < pv[p]);
        ireq = ($urandom_range(99) < pr[p]);
        ibit = W'($urandom);
        if ($urandom_range(39) == 0) modOrder = 3'($urandom_range(7));
        cyc(1);
      end
      if (p == 1) begin
        ival = 1'b1;
        ireq = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_oval", int'(oval), 0);
        chk("arst_oI", int'(oI), 0);
        chk("arst_oQ", int'(oQ), 0);
        chk("arst_oreq", int'(oreq), 0);
        chk("arst_uflow", int'(ounderflow), 0);
        ival = 1'b0;
        ireq = 1'b0;
        cyc(2);
        rst = 1'b0;
        modOrder = 3'd4;
        cyc(2);
        chk("arst_fifo_empty_oreq", int'(oreq), 1);
      end
    end
    ival = 1'b0;
    ireq = 1'b0;
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qam_mapper.md
QAM_MAPPER -- requirements
Module: qam_mapper

Interface
REQ-001 SHALL have parameter maxWordOut, default 6, input word width in bits.
REQ-002 SHALL have parameter AMP_W, default 12, signed I/Q amplitude width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output symbol FIFO entries (power of two, >=4).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 modOrder  input  3  requested bits/symbol; legal values 1, 2, 4, 6.
REQ-007 oreq  output  1  word request to the upstream serial-to-parallel stage.
REQ-008 ival  input  1  upstream word valid.
REQ-009 ibit  input  maxWordOut  upstream word, LSB-aligned.
REQ-010 ireq  input  1  symbol request from the downstream shaping filter.
REQ-011 oval  output  1  symbol valid.
REQ-012 oI, oQ  output  AMP_W each  signed in-phase and quadrature amplitudes.
REQ-013 ounderflow  output  1  sticky flag: ireq seen while FIFO empty in RUN.

Function
REQ-014 FSM SHALL have states IDLE, RUN and DRAIN.
REQ-015 IDLE: oreq=0; on a legal modOrder, latch it into curOrder and go to RUN next cycle; illegal values are ignored.
REQ-016 RUN: oreq=1 iff FIFO occupancy <= FIFO_DEPTH-2, leaving one slot for an in-flight word.
REQ-017 RUN: a legal modOrder != curOrder SHALL send the FSM to DRAIN; an illegal value SHALL keep curOrder.
REQ-018 DRAIN: oreq=0; words still arriving are mapped with the old curOrder; when the FIFO is empty and ival=0, latch the new modOrder and return to RUN.
REQ-019 Any ival=1 cycle SHALL be accepted, including while oreq=0, and SHALL be mapped with curOrder.
REQ-020 Mapping SHALL take k=curOrder/2 bits per axis: I from ibit[2k-1:k], Q from ibit[k-1:0]. For curOrder=1: I from ibit[0], Q=0.
REQ-021 Gray levels, k=1: 0->-1, 1->+1.
REQ-022 Gray levels, k=2: 00->-3, 01->-1, 11->+1, 10->+3.
REQ-023 Gray levels, k=3: 000->-7, 001->-5, 011->-3, 010->-1, 110->+1, 111->+3, 101->+5, 100->+7.
REQ-024 Amplitude SHALL be level*STEP[curOrder], computed at full width and saturated to AMP_W.
REQ-025 The mapped symbol SHALL be registered one cycle after acceptance and written into the FIFO on that same edge.
REQ-026 A write arriving while the FIFO is full SHALL be dropped; no other state changes.
REQ-027 ireq=1 with FIFO non-empty SHALL pop one entry; oval=1 and oI/oQ show it the following cycle.
REQ-028 Otherwise oval=0 and oI=oQ=0.
REQ-029 A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-030 ireq=1 with FIFO empty in RUN SHALL set ounderflow=1 until reset; in IDLE or DRAIN it SHALL not.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-032 rst SHALL set state=IDLE, curOrder=0, FIFO empty, pipeline register cleared, oreq=0, oval=0, oI=oQ=0, ounderflow=0.
REQ-033 rst mid-operation SHALL discard all buffered and in-flight symbols immediately; the first oval is possible only after IDLE->RUN and a fresh accept.

Configuration
REQ-034 With QAM_MAPPER_NORM_EN defined, STEP SHALL be 1448, 1024, 458, 223 for orders 1, 2, 4, 6 (unit average power, full scale 2047 at AMP_W=12).
REQ-035 Without QAM_MAPPER_NORM_EN, STEP SHALL be 2^(AMP_W-4) for all orders (256 at default).

Structure
REQ-036 Package tx_mod_pkg SHALL hold the FSM state enum, legal order constants, Gray level tables and both STEP tables.
REQ-037 The FIFO SHALL be sub-module sym_fifo: parameterised depth and width, push/pop/full/empty/count.

Verification
REQ-038 Reset then modOrder=2 -> oreq=1 on the 2nd cycle after rst falls; ival with ibit=2'b10 -> ireq -> oI=+256, oQ=-256 (no macro).
REQ-039 modOrder=6, ibit=6'b100_000 -> oI=+1792, oQ=-1792 (no macro); with macro -> +1561/-1561.
REQ-040 Order 4 running with 3 entries, no ireq -> oreq=0; 2 more words forced in -> 4th stored, 5th dropped, count=4.
REQ-041 Order 4->2 change with 2 entries buffered -> DRAIN, oreq=0; two ireq -> both symbols at order-4 scaling, then RUN at order 2.
REQ-042 ireq with FIFO empty in RUN -> ounderflow=1, oval=0; persists until rst.
REQ-043 rst pulsed asynchronously mid-burst -> all outputs 0 without waiting for a clk edge; FIFO empty afterwards.
